// File: rtl/regfile_loader_if.sv
// Byte-stream input and register-file write port of the loader.
// The slave modport is the loader's view; master is the surrounding datapath/source.
interface regfile_loader_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
);
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              we3;
  logic [ADDR_W-1:0] wa3;
  logic [DATA_W-1:0] wd3;

  modport master (
    output in_valid, in_data,
    input  in_ready, we3, wa3, wd3
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, we3, wa3, wd3
  );
endinterface

// File: rtl/regfile_loader.sv
// Fills registers 0..NREGS-1 from a little-endian byte stream, one word per
// LO/HI/WRITE round, and pulses done after the last write.
module regfile_loader #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter int NREGS  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  regfile_loader_if.slave  bus,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LO    = 3'd1,
    HI    = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NREGS - 1);

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        lo;
  logic [7:0]        hi;
  logic              hs;

  assign hs = bus.in_valid && bus.in_ready;

  // NOTE: all state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would let addr/lo/hi race the state update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      addr  <= '0;
      lo    <= '0;
      hi    <= '0;
    end else if (abort) begin
      state <= IDLE;
      addr  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            addr  <= '0;
            state <= LO;
          end
        end
        LO: begin
          if (hs) begin
            lo    <= bus.in_data;
            state <= HI;
          end
        end
        HI: begin
          if (hs) begin
            hi    <= bus.in_data;
            state <= WRITE;
          end
        end
        WRITE: begin
          if (addr == LAST_ADDR) begin
            state <= DONE;
          end else begin
            addr  <= addr + 1'b1;
            state <= LO;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs are pure decodes of registered state, so no input reaches an output
  // in the same cycle; an abort therefore never cancels the write already shown.
  assign bus.in_ready = (state == LO) || (state == HI);
  assign bus.we3      = (state == WRITE);
  assign bus.wa3      = addr;
  assign bus.wd3      = {hi, lo};
  assign busy         = (state != IDLE);
  assign done         = (state == DONE);

endmodule

// File: tb/tb_regfile_loader.sv
// Randomized bench for regfile_loader: expected writes come from the byte list
// itself (word r = {byte 2r+1, byte 2r}) and the cycle timeline of the load.
module tb_regfile_loader;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 3;
  localparam int NREGS  = 8;
  localparam int NONE   = -1000;

  logic clk;
  logic rst_n;
  logic start;
  logic abort;
  logic busy;
  logic done;

  regfile_loader_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  regfile_loader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREGS(NREGS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .abort (abort),
    .bus   (bus),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc_cnt = 0;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Observed activity: commit edge of each write, cycle in which done is high.
  int          wr_addr[$];
  logic [15:0] wr_data[$];
  int          wr_cyc[$];
  int          done_cyc[$];

  always @(negedge clk) begin
    if (bus.we3 === 1'b1) begin
      wr_addr.push_back(int'(bus.wa3));
      wr_data.push_back(bus.wd3);
      wr_cyc.push_back(cyc_cnt + 1);
    end
    if (done === 1'b1) done_cyc.push_back(cyc_cnt);
  end

  // Byte list of the current load (model input) and the bytes still to send.
  logic [7:0] sent[$];
  logic [7:0] stream[$];

  function automatic logic [15:0] model_word(input int r);
    return {sent[2*r+1], sent[2*r]};
  endfunction

  task automatic clear_logs();
    wr_addr.delete();
    wr_data.delete();
    wr_cyc.delete();
    done_cyc.delete();
  endtask

  task automatic fill_random();
    sent.delete();
    for (int i = 0; i < 2*NREGS; i++) sent.push_back(8'($urandom));
  endtask

  // Starts a load and feeds the stream until busy falls. abort_rel/start_rel are
  // cycles after E0 (the edge sampling start) at which to drive abort/start.
  task automatic run_load(input int stall_pct, input int abort_rel, input int start_rel,
                          output int e0, output int consumed, output int stalls,
                          output bit timed_out);
    int guard;
    guard = 0; consumed = 0; stalls = 0; timed_out = 1'b0;
    stream = sent;
    clear_logs();
    @(negedge clk);
    start = 1'b1;
    e0 = cyc_cnt + 1;
    @(negedge clk);
    start = 1'b0;
    while (busy === 1'b1) begin
      if (guard++ > 400) begin
        timed_out = 1'b1;
        break;
      end
      abort = (cyc_cnt == e0 + abort_rel);
      start = (cyc_cnt == e0 + start_rel);
      if (abort || stream.size() == 0) bus.in_valid = 1'b0;
      else bus.in_valid = ($urandom_range(99) >= stall_pct);
      bus.in_data = bus.in_valid ? stream[0] : 8'($urandom);
      if (bus.in_ready === 1'b1 && !abort) begin
        if (bus.in_valid) begin
          void'(stream.pop_front());
          consumed++;
        end else begin
          stalls++;
        end
      end
      @(negedge clk);
    end
    abort = 1'b0;
    start = 1'b0;
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    int e0, consumed, stalls;
    bit to;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({busy, done, bus.in_ready, bus.we3, bus.wa3, bus.wd3} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %b expected all zero",
               {busy, done, bus.in_ready, bus.we3, bus.wa3, bus.wd3});
    end
    rst_n = 1'b1;
    // Drive into HI of r0, then pull reset asynchronously.
    sent = '{8'h11, 8'h22};
    clear_logs();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data = 8'h11;
    @(negedge clk);
    n_cmp++;
    if (!(busy === 1'b1 && bus.in_ready === 1'b1 && bus.we3 === 1'b0)) begin
      n_bad++;
      $display("FAIL reset_prestate: got busy=%b ready=%b we3=%b expected 1 1 0",
               busy, bus.in_ready, bus.we3);
    end
    bus.in_data = 8'h22;
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({busy, done, bus.in_ready, bus.we3, bus.wa3, bus.wd3} !== '0) begin
      n_bad++;
      $display("FAIL reset_midload: got %b expected all zero",
               {busy, done, bus.in_ready, bus.we3, bus.wa3, bus.wd3});
    end
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (wr_addr.size() != 0 || done_cyc.size() != 0) begin
      n_bad++;
      $display("FAIL reset_nowrite: got writes=%0d dones=%0d expected 0 0",
               wr_addr.size(), done_cyc.size());
    end
    rst_n = 1'b1;
    fill_random();
    run_load(0, NONE, NONE, e0, consumed, stalls, to);
    n_cmp++;
    if (to || wr_addr.size() != NREGS || wr_addr[0] !== 0 || wr_data[0] !== model_word(0)) begin
      n_bad++;
      $display("FAIL reset_reload: got timeout=%0b writes=%0d expected 0 %0d from r0",
               to, wr_addr.size(), NREGS);
    end
  endtask

  task automatic test_back_to_back();
    int e0, consumed, stalls;
    bit to;
    sent.delete();
    for (int r = 0; r < NREGS; r++) begin
      sent.push_back(8'(r + 1));
      sent.push_back(8'h00);
    end
    run_load(0, NONE, NONE, e0, consumed, stalls, to);
    n_cmp++;
    if (to || wr_addr.size() != NREGS || consumed != 2*NREGS) begin
      n_bad++;
      $display("FAIL b2b_count: got timeout=%0b writes=%0d bytes=%0d expected 0 %0d %0d",
               to, wr_addr.size(), consumed, NREGS, 2*NREGS);
    end
    for (int r = 0; r < wr_addr.size() && r < NREGS; r++) begin
      n_cmp++;
      if (wr_addr[r] !== r || wr_data[r] !== 16'(r + 1) || wr_cyc[r] !== e0 + 3*r + 3) begin
        n_bad++;
        $display("FAIL b2b_write[%0d]: got wa3=%0d wd3=%h edge=E0+%0d expected %0d %h E0+%0d",
                 r, wr_addr[r], wr_data[r], wr_cyc[r] - e0, r, 16'(r + 1), 3*r + 3);
      end
    end
    n_cmp++;
    if (done_cyc.size() != 1 || done_cyc[0] != e0 + 24 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_done: got dones=%0d at E0+%0d busy=%b expected 1 at E0+24 busy=0",
               done_cyc.size(), (done_cyc.size() > 0) ? done_cyc[0] - e0 : -1, busy);
    end
  endtask

  task automatic test_byte_order();
    int e0, consumed, stalls;
    bit to;
    fill_random();
    sent[0] = 8'hCD;
    sent[1] = 8'hAB;
    run_load(0, NONE, NONE, e0, consumed, stalls, to);
    n_cmp++;
    if (to || wr_addr.size() == 0 || wr_addr[0] !== 0 || wr_data[0] !== 16'hABCD) begin
      n_bad++;
      $display("FAIL byte_order: got wa3=%0d wd3=%h expected 0 abcd",
               (wr_addr.size() > 0) ? wr_addr[0] : -1,
               (wr_data.size() > 0) ? wr_data[0] : 16'hxxxx);
    end
  endtask

  task automatic test_stalled();
    int e0, consumed, stalls, bad;
    bit to;
    for (int run = 0; run < 4; run++) begin
      if (run == 0) begin
        sent.delete();
        for (int r = 0; r < NREGS; r++) begin
          sent.push_back(8'(r + 1));
          sent.push_back(8'h00);
        end
      end else begin
        fill_random();
      end
      run_load(20 + 15*run, NONE, NONE, e0, consumed, stalls, to);
      n_cmp++;
      if (to || wr_addr.size() != NREGS || consumed != 2*NREGS) begin
        n_bad++;
        $display("FAIL stall%0d_count: got timeout=%0b writes=%0d bytes=%0d expected 0 %0d %0d",
                 run, to, wr_addr.size(), consumed, NREGS, 2*NREGS);
      end
      bad = 0;
      for (int r = 0; r < wr_addr.size() && r < NREGS; r++)
        if (wr_addr[r] !== r || wr_data[r] !== model_word(r)) bad++;
      n_cmp++;
      if (bad != 0) begin
        n_bad++;
        $display("FAIL stall%0d_data: got %0d wrong writes expected 0", run, bad);
      end
      n_cmp++;
      if (done_cyc.size() != 1 || done_cyc[0] != e0 + 24 + stalls) begin
        n_bad++;
        $display("FAIL stall%0d_done: got dones=%0d at E0+%0d expected 1 at E0+%0d",
                 run, done_cyc.size(), (done_cyc.size() > 0) ? done_cyc[0] - e0 : -1,
                 24 + stalls);
      end
    end
  endtask

  task automatic test_abort();
    int e0, consumed, stalls;
    bit to;
    // Abort sampled while in HI of r3 (state entered at E0+10).
    fill_random();
    run_load(0, 10, NONE, e0, consumed, stalls, to);
    n_cmp++;
    if (to || wr_addr.size() != 3 || consumed != 7 || done_cyc.size() != 0 ||
        busy !== 1'b0 || bus.in_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_hi: got writes=%0d bytes=%0d dones=%0d busy=%b expected 3 7 0 0",
               wr_addr.size(), consumed, done_cyc.size(), busy);
    end
    for (int r = 0; r < wr_addr.size() && r < 3; r++) begin
      n_cmp++;
      if (wr_addr[r] !== r || wr_data[r] !== model_word(r)) begin
        n_bad++;
        $display("FAIL abort_hi_write[%0d]: got %0d/%h expected %0d/%h",
                 r, wr_addr[r], wr_data[r], r, model_word(r));
      end
    end
    // Abort sampled while in WRITE of r5 (state entered at E0+17): r5 still lands.
    fill_random();
    run_load(0, 17, NONE, e0, consumed, stalls, to);
    n_cmp++;
    if (to || wr_addr.size() != 6 || consumed != 12 || done_cyc.size() != 0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_write: got writes=%0d bytes=%0d dones=%0d busy=%b expected 6 12 0 0",
               wr_addr.size(), consumed, done_cyc.size(), busy);
    end
    n_cmp++;
    if (wr_addr.size() < 6 || wr_addr[5] !== 5 || wr_data[5] !== model_word(5)) begin
      n_bad++;
      $display("FAIL abort_write_r5: got %0d writes expected r5=%h last",
               wr_addr.size(), model_word(5));
    end
    // start and abort together in IDLE: abort wins.
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || bus.in_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL start_abort_idle: got busy=%b ready=%b expected 0 0", busy, bus.in_ready);
    end
  endtask

  task automatic test_ignored_start();
    int e0, consumed, stalls, bad;
    bit to;
    fill_random();
    // LO of r2 is entered at E0+6; start sampled there must be ignored.
    run_load(0, NONE, 6, e0, consumed, stalls, to);
    bad = 0;
    for (int r = 0; r < wr_addr.size() && r < NREGS; r++)
      if (wr_addr[r] !== r || wr_data[r] !== model_word(r) || wr_cyc[r] !== e0 + 3*r + 3) bad++;
    n_cmp++;
    if (to || wr_addr.size() != NREGS || bad != 0 || consumed != 2*NREGS) begin
      n_bad++;
      $display("FAIL ignored_start: got writes=%0d wrong=%0d bytes=%0d expected %0d 0 %0d",
               wr_addr.size(), bad, consumed, NREGS, 2*NREGS);
    end
    n_cmp++;
    if (done_cyc.size() != 1 || done_cyc[0] != e0 + 24) begin
      n_bad++;
      $display("FAIL ignored_start_done: got dones=%0d expected 1 at E0+24", done_cyc.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of run expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    start = 1'b0;
    abort = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = 8'h00;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    test_reset();
    test_back_to_back();
    test_byte_order();
    test_stalled();
    test_abort();
    test_ignored_start();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
